// File: rtl/mul_result_buffer.sv
// Writeback-side buffer for integer multiply results: selects the architectural
// result from the double-width product and queues it in a 2-entry FIFO.
module mul_result_buffer #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushW,
  input  logic              MulValidM,
  output logic              MulReadyM,
  input  logic [2*XLEN-1:0] ProdM,
  input  logic [2:0]        Funct3M,
  input  logic              W64M,
  input  logic [4:0]        RdM,
  output logic              MulValidW,
  input  logic              WBReadyW,
  output logic [XLEN-1:0]   MulResultW,
  output logic [4:0]        RdW,
  output logic [31:0]       MulStallCount
);

  logic [XLEN-1:0] result_m;
  logic [XLEN-1:0] data_q [2];
  logic [4:0]      rd_q   [2];
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic [31:0]     stall_q, stall_d;
  logic            enq, deq, wr_en;

  // Word ops only exist on RV64; the 32-bit build has no W64 path at all.
  generate
    if (XLEN == 64) begin : g_rv64
      always_comb begin
        result_m = (Funct3M == 3'b000) ? ProdM[XLEN-1:0] : ProdM[2*XLEN-1:XLEN];
        if (W64M) result_m = {{(XLEN-32){ProdM[31]}}, ProdM[31:0]};
      end
    end else begin : g_rv32
      logic unused_w64;
      assign unused_w64 = W64M;
      always_comb begin
        result_m = (Funct3M == 3'b000) ? ProdM[XLEN-1:0] : ProdM[2*XLEN-1:XLEN];
      end
    end
  endgenerate

  assign MulReadyM = (count_q != 2'd2);
  assign MulValidW = (count_q != 2'd0);
  assign enq       = MulValidM & MulReadyM;
  assign deq       = MulValidW & WBReadyW;
  assign wr_en     = enq & ~FlushW;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    if (MulValidM && !MulReadyM) stall_d = stall_q + 32'd1;
    if (FlushW) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (enq) tail_d = ~tail_q;
      if (deq) head_d = ~head_q;
      case ({enq, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      stall_q <= 32'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage survives a flush; only reset clears it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!reset) begin
          data_q[gi] <= '0;
          rd_q[gi]   <= 5'd0;
        end else if (wr_en && (tail_q == gi[0])) begin
          data_q[gi] <= result_m;
          rd_q[gi]   <= RdM;
        end
      end
    end
  endgenerate

  assign MulResultW    = data_q[head_q];
  assign RdW           = rd_q[head_q];
  assign MulStallCount = stall_q;

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed self-checking bench for mul_result_buffer (XLEN=64).
module tb_mul_result_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         FlushW;
  logic         MulValidM;
  logic         MulReadyM;
  logic [127:0] ProdM;
  logic [2:0]   Funct3M;
  logic         W64M;
  logic [4:0]   RdM;
  logic         MulValidW;
  logic         WBReadyW;
  logic [63:0]  MulResultW;
  logic [4:0]   RdW;
  logic [31:0]  MulStallCount;

  int checks = 0;
  int errors = 0;

  mul_result_buffer #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .FlushW(FlushW),
    .MulValidM(MulValidM), .MulReadyM(MulReadyM), .ProdM(ProdM),
    .Funct3M(Funct3M), .W64M(W64M), .RdM(RdM),
    .MulValidW(MulValidW), .WBReadyW(WBReadyW), .MulResultW(MulResultW),
    .RdW(RdW), .MulStallCount(MulStallCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] p, input logic [2:0] f,
                       input logic w, input logic [4:0] rd);
    MulValidM = v; ProdM = p; Funct3M = f; W64M = w; RdM = rd;
  endtask

  initial begin
    reset = 1'b0; FlushW = 1'b0; WBReadyW = 1'b0;
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    tick(); tick();
    check("rst_valid", {63'd0, MulValidW}, 64'd0);
    check("rst_result", MulResultW, 64'd0);
    check("rst_rd", {59'd0, RdW}, 64'd0);
    check("rst_stall", {32'd0, MulStallCount}, 64'd0);
    reset = 1'b1;
    tick();
    check("rst_ready", {63'd0, MulReadyM}, 64'd1);
    check("rst_idle_valid", {63'd0, MulValidW}, 64'd0);

    // Result select
    WBReadyW = 1'b1;
    drive(1'b1, 128'h00000000_00000002_FFFFFFFF_80000001, 3'b000, 1'b0, 5'd1);
    tick();
    check("mul_valid", {63'd0, MulValidW}, 64'd1);
    check("mul_result", MulResultW, 64'hFFFFFFFF80000001);
    check("mul_rd", {59'd0, RdW}, 64'd1);
    drive(1'b1, 128'h00000000_00000002_FFFFFFFF_80000001, 3'b011, 1'b0, 5'd2);
    tick();
    check("mulhu_result", MulResultW, 64'h0000000000000002);
    check("mulhu_rd", {59'd0, RdW}, 64'd2);
    drive(1'b1, 128'hDEADBEEF_CAFEF00D_12345678_7FFFFFFF, 3'b000, 1'b1, 5'd3);
    tick();
    check("mulw_pos", MulResultW, 64'h000000007FFFFFFF);
    drive(1'b1, 128'h11111111_22222222_00000000_80000000, 3'b011, 1'b1, 5'd4);
    tick();
    check("mulw_neg", MulResultW, 64'hFFFFFFFF80000000);
    drive(1'b1, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 3'b100, 1'b0, 5'd0);
    tick();
    check("reserved_hi", MulResultW, 64'hAAAAAAAA_BBBBBBBB);
    check("rd0_pass", {59'd0, RdW}, 64'd0);
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    tick();
    check("drain_valid", {63'd0, MulValidW}, 64'd0);

    // Backpressure and stall counting
    WBReadyW = 1'b0;
    drive(1'b1, 128'd5, 3'b000, 1'b0, 5'd5);
    tick();
    check("bp_ready1", {63'd0, MulReadyM}, 64'd1);
    drive(1'b1, 128'd6, 3'b000, 1'b0, 5'd6);
    tick();
    check("bp_ready0", {63'd0, MulReadyM}, 64'd0);
    drive(1'b1, 128'd7, 3'b000, 1'b0, 5'd7);
    tick(); tick(); tick();
    check("bp_stall3", {32'd0, MulStallCount}, 64'd3);
    check("bp_head5", {59'd0, RdW}, 64'd5);
    check("bp_res5", MulResultW, 64'd5);
    WBReadyW = 1'b1;
    tick();
    check("bp_head6", {59'd0, RdW}, 64'd6);
    check("bp_ready_again", {63'd0, MulReadyM}, 64'd1);
    tick();
    check("bp_head7", {59'd0, RdW}, 64'd7);
    check("bp_res7", MulResultW, 64'd7);
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    tick();
    check("bp_empty", {63'd0, MulValidW}, 64'd0);
    check("bp_stall4", {32'd0, MulStallCount}, 64'd4);

    // Simultaneous enqueue/dequeue at count=1
    WBReadyW = 1'b0;
    drive(1'b1, 128'd8, 3'b000, 1'b0, 5'd8);
    tick();
    check("sim_head8", {59'd0, RdW}, 64'd8);
    WBReadyW = 1'b1;
    drive(1'b1, 128'd9, 3'b000, 1'b0, 5'd9);
    tick();
    check("sim_head9", {59'd0, RdW}, 64'd9);
    check("sim_valid", {63'd0, MulValidW}, 64'd1);
    check("sim_ready", {63'd0, MulReadyM}, 64'd1);
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    tick();
    check("sim_empty", {63'd0, MulValidW}, 64'd0);

    // Flush with two entries and a pending producer
    WBReadyW = 1'b0;
    drive(1'b1, 128'd1, 3'b000, 1'b0, 5'd1);
    tick();
    drive(1'b1, 128'd2, 3'b000, 1'b0, 5'd2);
    tick();
    FlushW = 1'b1;
    drive(1'b1, 128'd3, 3'b000, 1'b0, 5'd3);
    tick();
    FlushW = 1'b0;
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    check("fl2_valid", {63'd0, MulValidW}, 64'd0);
    check("fl2_ready", {63'd0, MulReadyM}, 64'd1);
    tick();
    check("fl2_still_empty", {63'd0, MulValidW}, 64'd0);
    // Flush at count=1 while an enqueue is accepted: the enqueue is lost
    drive(1'b1, 128'd4, 3'b000, 1'b0, 5'd4);
    tick();
    FlushW = 1'b1;
    drive(1'b1, 128'd3, 3'b000, 1'b0, 5'd3);
    tick();
    FlushW = 1'b0;
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    check("fl1_valid", {63'd0, MulValidW}, 64'd0);
    check("fl_stall5", {32'd0, MulStallCount}, 64'd5);
    // After flush the next entry lands in slot 0 and is the one shown
    drive(1'b1, 128'd10, 3'b000, 1'b0, 5'd10);
    tick();
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    check("fl_next_rd", {59'd0, RdW}, 64'd10);
    check("fl_next_cnt1", {63'd0, MulReadyM}, 64'd1);

    // Reset mid-stream with count=2 and stalls accumulated
    drive(1'b1, 128'd12, 3'b000, 1'b0, 5'd12);
    tick();
    tick();
    check("mid_stall6", {32'd0, MulStallCount}, 64'd6);
    reset = 1'b0;
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    tick();
    check("mid_rst_valid", {63'd0, MulValidW}, 64'd0);
    check("mid_rst_result", MulResultW, 64'd0);
    check("mid_rst_rd", {59'd0, RdW}, 64'd0);
    check("mid_rst_stall", {32'd0, MulStallCount}, 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", {63'd0, MulReadyM}, 64'd1);
    check("post_rst_valid", {63'd0, MulValidW}, 64'd0);
    drive(1'b1, 128'h0000000000000000_00000000000000AB, 3'b000, 1'b0, 5'd11);
    tick();
    drive(1'b0, '0, 3'b000, 1'b0, 5'd0);
    check("post_rst_enq_valid", {63'd0, MulValidW}, 64'd1);
    check("post_rst_enq_rd", {59'd0, RdW}, 64'd11);
    check("post_rst_enq_res", MulResultW, 64'hAB);
    WBReadyW = 1'b1;
    tick();
    check("post_rst_drain", {63'd0, MulValidW}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_result_buffer.md
Name: mul_result_buffer

Overview:
- Memory/Writeback stage consumer of the double-width product from the integer multiplier.
- Selects the architectural result for MUL/MULH/MULHSU/MULHU/MULW from ProdM.
- Holds results in a 2-entry FIFO and presents them through a valid/ready handshake to the shared writeback port.
- Backpressures the pipeline when full and counts backpressure cycles for performance monitoring.

Parameters:
- XLEN, 64, datapath width (32 or 64); ProdM is 2*XLEN bits.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- FlushW  input  1  synchronous flush of all buffered results.
- MulValidM  input  1  ProdM/Funct3M/W64M/RdM carry a completed multiply this cycle.
- MulReadyM  output  1  buffer can accept an entry this cycle.
- ProdM  input  2*XLEN  double-width product from the multiplier.
- Funct3M  input  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- W64M  input  1  RV64 word op (MULW); ignored when XLEN=32.
- RdM  input  5  destination register.
- MulValidW  output  1  head entry valid.
- WBReadyW  input  1  writeback port accepts head entry.
- MulResultW  output  XLEN  head entry result.
- RdW  output  5  head entry destination.
- MulStallCount  output  32  cycles with MulValidM=1 and MulReadyM=0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low: when reset=0 at a rising edge, all state clears.
- Reset values:
  - count=0, head/tail pointers=0, entry data/rd=0.
  - MulValidW=0, MulResultW=0, RdW=0, MulStallCount=0.
  - MulReadyM=1 in the cycle after reset deasserts.
- Result select (combinational, M stage):
  - W64M=1 and XLEN=64: result = sign-extend(ProdM[31:0]) regardless of Funct3M.
  - Else if Funct3M=000: result = ProdM[XLEN-1:0].
  - Else (001/010/011, and reserved 1xx): result = ProdM[2*XLEN-1:XLEN].
- FIFO:
  - Depth 2 with count in {0,1,2}.
  - MulReadyM = (count<2), purely from registered count; no combinational path from WBReadyW.
  - Enqueue when MulValidM & MulReadyM; writes the tail entry.
  - Dequeue when MulValidW & WBReadyW; advances head.
  - Simultaneous enqueue and dequeue at count=1: count stays 1, ordering preserved. Enqueue cannot occur at count=2.
  - Pointers wrap modulo 2.
- Outputs:
  - MulValidW = (count!=0).
  - MulResultW/RdW are driven from the head entry registers.
  - When empty, MulResultW/RdW show the stale head contents; the consumer ignores them.
- Latency: an entry enqueued at edge N is visible on MulValidW/MulResultW after edge N, i.e. 1 cycle.
- Rd=0: passed through unchanged; suppression is the writeback's job.
- FlushW:
  - count and pointers go to 0 at the edge; an enqueue in the same cycle is discarded.
  - Entry data is not cleared.
  - MulStallCount is unaffected.
- reset has priority over FlushW.
- MulStallCount increments each cycle with MulValidM & !MulReadyM and wraps at 2^32.
- Reset mid-operation drops all buffered entries. After reset deasserts, no MulValidW occurs until a new enqueue.
- Protocol rules:
  - The producer holds MulValidM and its payload stable until accepted.
  - The consumer may drop WBReadyW at any time.
  - The buffer never drops or duplicates an entry except on flush or reset.

Test Plan:
- XLEN=64, ProdM=0x00000000_00000002_FFFFFFFF_80000001, WBReadyW=1:
  - Funct3M=000, W64M=0 -> MulResultW=0xFFFFFFFF80000001 one cycle later.
  - Funct3M=011 -> 0x0000000000000002.
- W64M=1, ProdM low word 0x12345678_7FFFFFFF -> MulResultW=0x000000007FFFFFFF. Low word 0x00000000_80000000 -> 0xFFFFFFFF80000000.
- WBReadyW=0, enqueue Rd=5, then Rd=6, then hold a third MulValidM for 3 cycles:
  - MulReadyM=0 after the second enqueue; MulStallCount=3.
  - Then raise WBReadyW: RdW sequence 5, 6, 7 with no loss or duplicates.
- count=1 with simultaneous enqueue (Rd=9) and dequeue (Rd=8) -> RdW=9 next cycle, MulValidW=1, MulReadyM stays 1.
- Two entries buffered, FlushW=1 with MulValidM=1 (Rd=3) -> next cycle MulValidW=0, MulReadyM=1, Rd=3 never appears.
- reset=0 mid-stream with count=2 and MulStallCount nonzero -> next cycle all outputs at reset values. Release reset: first enqueued result appears one cycle after acceptance.
